// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared phase enum, 640x480@60 defaults and timing helpers
package vga_timing_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } phase_e;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int MAX_TOTAL     = 1024;

  function automatic int frame_total(input int disp, input int front, input int sync, input int back);
    return disp + front + sync + back;
  endfunction

  function automatic int sync_start(input int disp, input int front);
    return disp + front;
  endfunction

  function automatic int sync_end(input int disp, input int front, input int sync);
    return disp + front + sync - 1;
  endfunction

  // Phase boundaries are the last position of each phase.
  function automatic phase_e next_phase(input phase_e cur, input logic [9:0] pos,
                                        input logic [9:0] act_end, input logic [9:0] fp_end,
                                        input logic [9:0] sy_end, input logic [9:0] last);
    phase_e nxt;
    nxt = cur;
    case (cur)
      ACTIVE:  if (pos == act_end) nxt = FRONT;
      FRONT:   if (pos == fp_end)  nxt = SYNC;
      SYNC:    if (pos == sy_end)  nxt = BACK;
      default: if (pos == last)    nxt = ACTIVE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_delay.sv
// rtl/vga_timing_ctrl_delay.sv - vga_sync_delay: DEPTH-stage re-timing of {hsync, vsync, display_on}
module vga_sync_delay #(
  parameter int   DEPTH    = 1,
  parameter logic SYNC_OFF = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] din,
  output logic [2:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ok;
    assign unused_ok = ^{clk, rst};
    assign dout = din;
  end else begin : g_shift
    localparam logic [2:0] RST_VAL = {SYNC_OFF, SYNC_OFF, 1'b0};
    logic [2:0] stage [DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      end else begin
        stage[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - VGA beam sequencer with re-timed sync/blank outputs
// Optional frame counter enabled by defining VGA_TIMING_FRAME_COUNTER_EN.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY        = DEF_H_DISPLAY,
  parameter int H_FRONT          = DEF_H_FRONT,
  parameter int H_SYNC           = DEF_H_SYNC,
  parameter int H_BACK           = DEF_H_BACK,
  parameter int V_DISPLAY        = DEF_V_DISPLAY,
  parameter int V_FRONT          = DEF_V_FRONT,
  parameter int V_SYNC           = DEF_V_SYNC,
  parameter int V_BACK           = DEF_V_BACK,
  parameter int SYNC_ACTIVE_HIGH = 0,
  parameter int PIPE_DEPTH       = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_ce,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       display_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start,
  output logic       hsync_d,
  output logic       vsync_d,
  output logic       display_on_d,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL = frame_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = frame_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_size_check
    $error("vga_timing_ctrl: timing totals exceed 10-bit counter range");
  end
  if (PIPE_DEPTH < 0 || PIPE_DEPTH > 7) begin : g_depth_check
    $error("vga_timing_ctrl: PIPE_DEPTH must be 0..7");
  end

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_ACT_END = 10'(H_DISPLAY - 1);
  localparam logic [9:0] H_FP_END  = 10'(sync_start(H_DISPLAY, H_FRONT) - 1);
  localparam logic [9:0] H_SY_END  = 10'(sync_end(H_DISPLAY, H_FRONT, H_SYNC));
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_ACT_END = 10'(V_DISPLAY - 1);
  localparam logic [9:0] V_FP_END  = 10'(sync_start(V_DISPLAY, V_FRONT) - 1);
  localparam logic [9:0] V_SY_END  = 10'(sync_end(V_DISPLAY, V_FRONT, V_SYNC));
  localparam logic       SYNC_ON   = (SYNC_ACTIVE_HIGH != 0);
  localparam logic       SYNC_OFF  = ~SYNC_ON;

  phase_e     h_state, v_state, h_state_nxt, v_state_nxt;
  logic [9:0] hpos_nxt, vpos_nxt;
  logic       h_wrap, v_wrap;

  always_comb begin
    h_wrap      = (hpos == H_LAST);
    v_wrap      = (vpos == V_LAST);
    hpos_nxt    = h_wrap ? 10'd0 : hpos + 10'd1;
    vpos_nxt    = vpos;
    h_state_nxt = next_phase(h_state, hpos, H_ACT_END, H_FP_END, H_SY_END, H_LAST);
    v_state_nxt = v_state;
    if (h_wrap) begin
      vpos_nxt    = v_wrap ? 10'd0 : vpos + 10'd1;
      v_state_nxt = next_phase(v_state, vpos, V_ACT_END, V_FP_END, V_SY_END, V_LAST);
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as hpos/vpos.
  always_ff @(posedge clk) begin
    if (rst) begin
      hpos        <= '0;
      vpos        <= '0;
      h_state     <= ACTIVE;
      v_state     <= ACTIVE;
      display_on  <= 1'b1;
      hsync       <= SYNC_OFF;
      vsync       <= SYNC_OFF;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_ce) begin
      hpos        <= hpos_nxt;
      vpos        <= vpos_nxt;
      h_state     <= h_state_nxt;
      v_state     <= v_state_nxt;
      display_on  <= (h_state_nxt == ACTIVE) && (v_state_nxt == ACTIVE);
      hsync       <= (h_state_nxt == SYNC) ? SYNC_ON : SYNC_OFF;
      vsync       <= (v_state_nxt == SYNC) ? SYNC_ON : SYNC_OFF;
      line_start  <= h_wrap;
      frame_start <= h_wrap && v_wrap;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_TIMING_FRAME_COUNTER_EN
  logic [7:0] frame_q;
  always_ff @(posedge clk) begin
    if (rst) frame_q <= '0;
    else if (pix_ce && h_wrap && v_wrap) frame_q <= frame_q + 8'd1;
  end
  assign frame_cnt = frame_q;
`else
  assign frame_cnt = 8'd0;
`endif

  logic [2:0] dly_out;

  vga_sync_delay #(
    .DEPTH    (PIPE_DEPTH),
    .SYNC_OFF (SYNC_OFF)
  ) u_sync_delay (
    .clk  (clk),
    .rst  (rst),
    .din  ({hsync, vsync, display_on}),
    .dout (dly_out)
  );

  assign {hsync_d, vsync_d, display_on_d} = dly_out;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb/tb_vga_timing_ctrl.sv - directed bench: full-size 640x480 instance (PIPE_DEPTH=3)
// plus a tiny 8x6 instance (PIPE_DEPTH=0) for whole-frame and frame-counter runs.
module tb_vga_timing_ctrl;

`ifdef VGA_TIMING_FRAME_COUNTER_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif
  localparam int S_FRAME = 48;
  localparam logic [2:0] CLEARED = 3'b110;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_ce = 1'b0;
  int checks = 0;
  int failures = 0;

  logic [9:0] hpos, vpos, s_hpos, s_vpos;
  logic display_on, hsync, vsync, line_start, frame_start, hsync_d, vsync_d, display_on_d;
  logic s_display_on, s_hsync, s_vsync, s_line_start, s_frame_start, s_hsync_d, s_vsync_d, s_display_on_d;
  logic [7:0] frame_cnt, s_frame_cnt;

  always #5 clk = ~clk;

  vga_timing_ctrl #(.PIPE_DEPTH(3)) dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .hpos(hpos), .vpos(vpos),
    .display_on(display_on), .hsync(hsync), .vsync(vsync),
    .line_start(line_start), .frame_start(frame_start),
    .hsync_d(hsync_d), .vsync_d(vsync_d), .display_on_d(display_on_d),
    .frame_cnt(frame_cnt)
  );

  vga_timing_ctrl #(
    .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_ACTIVE_HIGH(0), .PIPE_DEPTH(0)
  ) dut_s (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .hpos(s_hpos), .vpos(s_vpos),
    .display_on(s_display_on), .hsync(s_hsync), .vsync(s_vsync),
    .line_start(s_line_start), .frame_start(s_frame_start),
    .hsync_d(s_hsync_d), .vsync_d(s_vsync_d), .display_on_d(s_display_on_d),
    .frame_cnt(s_frame_cnt)
  );

  // {hsync, vsync, display_on} for the n-th pixel position of the 800x525 raster
  function automatic logic [2:0] model_def(input int n);
    int h, v;
    h = n % 800;
    v = (n / 800) % 525;
    return {!(h >= 656 && h <= 751), !(v >= 490 && v <= 491), (h < 640) && (v < 480)};
  endfunction

  // Same for the 8x6 raster: display 0..3/0..2, hsync at 5..6, vsync on line 4
  function automatic logic [2:0] model_s(input int n);
    int h, v;
    h = n % 8;
    v = (n / 8) % 6;
    return {!(h == 5 || h == 6), !(v == 4), (h < 4) && (v < 3)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    pix_ce = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    logic [33:0] got;
    do_reset();
    got = {hpos, vpos, display_on, hsync, vsync, line_start, frame_start, frame_cnt, hsync_d, vsync_d, display_on_d};
    checks++;
    if (got !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, CLEARED}) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", got, {10'd0, 10'd0, 5'b11100, 8'd0, CLEARED});
    end
    checks++;
    if ({s_hpos, s_vpos, s_display_on, s_hsync, s_vsync, s_frame_cnt} !== {20'd0, 3'b111, 8'd0}) begin
      failures++;
      $display("FAIL reset_state_small hpos=%0d vpos=%0d frame_cnt=%0d exp 0/0/0", s_hpos, s_vpos, s_frame_cnt);
    end
  endtask

  task automatic test_line;
    logic [2:0] hist [0:1023];
    logic [2:0] exp_d;
    int line_pulses;
    line_pulses = 0;
    do_reset();
    hist[0] = model_def(0);
    for (int k = 1; k <= 800; k++) begin
      tick();
      hist[k] = model_def(k);
      if (line_start) line_pulses++;
      checks++;
      if ({hpos, vpos, hsync, vsync, display_on, line_start, frame_start} !==
          {10'(k % 800), 10'(k / 800), hist[k], (k == 800), 1'b0}) begin
        failures++;
        $display("FAIL line_walk k=%0d got hpos=%0d vpos=%0d hs=%b vs=%b de=%b ls=%b fs=%b exp hpos=%0d vpos=%0d sig=%b ls=%b",
                 k, hpos, vpos, hsync, vsync, display_on, line_start, frame_start,
                 k % 800, k / 800, hist[k], (k == 800));
      end
      exp_d = (k >= 3) ? hist[k-3] : CLEARED;
      checks++;
      if ({hsync_d, vsync_d, display_on_d} !== exp_d) begin
        failures++;
        $display("FAIL delay3 k=%0d got=%b exp=%b", k, {hsync_d, vsync_d, display_on_d}, exp_d);
      end
    end
    checks++;
    if (line_pulses !== 1) begin
      failures++;
      $display("FAIL line_start_count got=%0d exp=1", line_pulses);
    end
  endtask

  task automatic test_small_frame;
    int de_count;
    de_count = 0;
    do_reset();
    for (int k = 1; k <= 3 * S_FRAME; k++) begin
      tick();
      if (k <= S_FRAME && s_display_on) de_count++;
      checks++;
      if ({s_hpos, s_vpos, s_hsync, s_vsync, s_display_on, s_line_start, s_frame_start,
           s_hsync_d, s_vsync_d, s_display_on_d, s_frame_cnt} !==
          {10'(k % 8), 10'((k / 8) % 6), model_s(k), (k % 8 == 0), (k % S_FRAME == 0),
           model_s(k), (FC_EN ? 8'(k / S_FRAME) : 8'd0)}) begin
        failures++;
        $display("FAIL small_frame k=%0d got hpos=%0d vpos=%0d sig=%b ls=%b fs=%b d=%b fc=%0d exp hpos=%0d vpos=%0d sig=%b",
                 k, s_hpos, s_vpos, {s_hsync, s_vsync, s_display_on}, s_line_start, s_frame_start,
                 {s_hsync_d, s_vsync_d, s_display_on_d}, s_frame_cnt, k % 8, (k / 8) % 6, model_s(k));
      end
    end
    checks++;
    if (de_count !== 12) begin
      failures++;
      $display("FAIL display_on_per_frame got=%0d exp=12", de_count);
    end
  endtask

  task automatic test_frame_wrap;
    do_reset();
    for (int k = 1; k <= 256 * S_FRAME; k++) begin
      tick();
      if (k == 255 * S_FRAME) begin
        checks++;
        if (s_frame_cnt !== (FC_EN ? 8'd255 : 8'd0)) begin
          failures++;
          $display("FAIL frame_cnt_255 got=%0d exp=%0d", s_frame_cnt, FC_EN ? 255 : 0);
        end
      end
    end
    checks++;
    if ({s_frame_cnt, s_frame_start, s_hpos, s_vpos} !== {8'd0, 1'b1, 20'd0}) begin
      failures++;
      $display("FAIL frame_cnt_wrap got fc=%0d fs=%b hpos=%0d vpos=%0d exp 0/1/0/0",
               s_frame_cnt, s_frame_start, s_hpos, s_vpos);
    end
  endtask

  task automatic test_pix_ce_toggle;
    logic [2:0] hist [0:2047];
    int n;
    do_reset();
    hist[0] = model_def(0);
    for (int c = 1; c <= 1604; c++) begin
      pix_ce = (c % 2 == 1);
      tick();
      n = (c + 1) / 2;
      hist[c] = model_def(n);
      checks++;
      if ({hpos, vpos, hsync, vsync, display_on, line_start} !==
          {10'(n % 800), 10'(n / 800), hist[c], ((c % 2 == 1) && (n == 800))}) begin
        failures++;
        $display("FAIL pix_ce_toggle c=%0d got hpos=%0d vpos=%0d sig=%b ls=%b exp hpos=%0d vpos=%0d sig=%b",
                 c, hpos, vpos, {hsync, vsync, display_on}, line_start, n % 800, n / 800, hist[c]);
      end
      checks++;
      if ({hsync_d, vsync_d, display_on_d} !== ((c >= 3) ? hist[c-3] : CLEARED)) begin
        failures++;
        $display("FAIL pix_ce_delay c=%0d got=%b exp=%b", c, {hsync_d, vsync_d, display_on_d},
                 (c >= 3) ? hist[c-3] : CLEARED);
      end
    end
    pix_ce = 1'b1;
  endtask

  task automatic test_reset_mid;
    do_reset();
    repeat (400) tick();
    checks++;
    if ({hpos, vpos, display_on_d} !== {10'd400, 10'd0, 1'b1}) begin
      failures++;
      $display("FAIL mid_pre got hpos=%0d vpos=%0d de_d=%b exp 400/0/1", hpos, vpos, display_on_d);
    end
    rst = 1'b1;
    pix_ce = 1'b0;
    tick();
    checks++;
    if ({hpos, vpos, display_on, hsync, vsync, frame_cnt, hsync_d, vsync_d, display_on_d} !==
        {20'd0, 3'b111, 8'd0, CLEARED}) begin
      failures++;
      $display("FAIL mid_reset got hpos=%0d vpos=%0d sig=%b fc=%0d d=%b exp 0/0/111/0/110",
               hpos, vpos, {display_on, hsync, vsync}, frame_cnt, {hsync_d, vsync_d, display_on_d});
    end
    rst = 1'b0;
    pix_ce = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (display_on_d !== (k == 3)) begin
        failures++;
        $display("FAIL mid_stages_cleared k=%0d got=%b exp=%b", k, display_on_d, (k == 3));
      end
    end
    // small raster: hit reset inside both sync pulses of the second frame
    do_reset();
    repeat (S_FRAME + 37) tick();
    checks++;
    if ({s_hsync, s_vsync, s_frame_cnt} !== {2'b00, (FC_EN ? 8'd1 : 8'd0)}) begin
      failures++;
      $display("FAIL mid_small_pre got hs=%b vs=%b fc=%0d", s_hsync, s_vsync, s_frame_cnt);
    end
    rst = 1'b1;
    pix_ce = 1'b0;
    tick();
    checks++;
    if ({s_hpos, s_vpos, s_hsync, s_vsync, s_frame_cnt} !== {20'd0, 2'b11, 8'd0}) begin
      failures++;
      $display("FAIL mid_small_reset got hpos=%0d vpos=%0d hs=%b vs=%b fc=%0d exp 0/0/1/1/0",
               s_hpos, s_vpos, s_hsync, s_vsync, s_frame_cnt);
    end
    rst = 1'b0;
    pix_ce = 1'b1;
  endtask

  initial begin
    test_reset();
    test_line();
    test_small_frame();
    test_frame_wrap();
    test_pix_ce_toggle();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
